// File: rtl/decimal_entry_if.sv
// Keypad entry bus: operator pulses in, BCD digits / cursor / conversion result out.
interface decimal_entry_if #(
  parameter int DIGITS = 4,
  parameter int WIDTH  = 10,
  parameter int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1
);
  logic                  inc;
  logic                  next;
  logic                  submit;
  logic                  clear;
  logic [4*DIGITS-1:0]   digits;
  logic [CW-1:0]         cursor;
  logic                  busy;
  logic [WIDTH-1:0]      value;
  logic                  valid;
  logic                  overflow;

  modport master (
    output inc, next, submit, clear,
    input  digits, cursor, busy, value, valid, overflow
  );

  modport slave (
    input  inc, next, submit, clear,
    output digits, cursor, busy, value, valid, overflow
  );
endinterface

// File: rtl/decimal_entry.sv
// Decimal keypad entry with sequential BCD-to-binary (x10 accumulate) conversion.
// Optional ENTRY_AUTOCLEAR_EN: zero the entry and home the cursor when a conversion completes.
module decimal_entry #(
  parameter int DIGITS = 4,
  parameter int WIDTH  = 10
) (
  input  logic            clk,
  input  logic            reset,
  decimal_entry_if.slave  bus
);
  // state | meaning
  // EDIT  | operator edits digits / moves cursor, waits for submit
  // CONV  | one digit per cycle folded into acc, MSD first
  // DONE  | result registered, valid pulse for one cycle
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int AW = WIDTH + 4;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  typedef enum logic [1:0] {EDIT, CONV, DONE} state_t;
  state_t state, state_next;

  logic [4*DIGITS-1:0] digits;
  logic [CW-1:0]       cursor;
  logic [CW-1:0]       idx;
  logic [AW-1:0]       acc;
  logic [AW-1:0]       acc_next;
  logic [WIDTH-1:0]    value;
  logic                overflow;
  logic [3:0]          cur_digit;
  logic [3:0]          conv_digit;
  logic [3:0]          digit_inc;
  logic [CW-1:0]       cursor_dec;
  logic                acc_ovf;

  assign cur_digit  = digits[{cursor, 2'b00} +: 4];
  assign conv_digit = digits[{idx, 2'b00} +: 4];
  assign digit_inc  = (cur_digit == 4'd9) ? 4'd0 : cur_digit + 4'd1;
  assign cursor_dec = (cursor == '0) ? LAST : cursor - 1'b1;
  assign acc_next   = (acc << 3) + (acc << 1) + AW'(conv_digit);
  assign acc_ovf    = |acc_next[AW-1:WIDTH];

  always_ff @(posedge clk) begin
    if (!reset) state <= EDIT;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (bus.clear) begin
      state_next = EDIT;
    end else begin
      case (state)
        EDIT:    if (bus.submit) state_next = CONV;
        CONV:    if (idx == '0) state_next = DONE;
        DONE:    state_next = EDIT;
        default: state_next = EDIT;
      endcase
    end
  end

  // Result is latched on the last CONV edge so it is already visible during DONE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      digits   <= '0;
      cursor   <= LAST;
      idx      <= LAST;
      acc      <= '0;
      value    <= '0;
      overflow <= 1'b0;
    end else if (bus.clear) begin
      digits <= '0;
      cursor <= LAST;
    end else begin
      case (state)
        EDIT: begin
          if (bus.submit) begin
            acc <= '0;
            idx <= LAST;
          end else begin
            if (bus.inc)  digits[{cursor, 2'b00} +: 4] <= digit_inc;
            if (bus.next) cursor <= cursor_dec;
          end
        end
        CONV: begin
          acc <= acc_next;
          idx <= idx - 1'b1;
          if (idx == '0) begin
            value    <= acc_ovf ? '1 : acc_next[WIDTH-1:0];
            overflow <= acc_ovf;
          end
        end
        DONE: begin
`ifdef ENTRY_AUTOCLEAR_EN
          digits <= '0;
          cursor <= LAST;
`else
          acc <= acc;
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.digits   = digits;
  assign bus.cursor   = cursor;
  assign bus.busy     = (state == CONV);
  assign bus.valid    = (state == DONE);
  assign bus.value    = value;
  assign bus.overflow = overflow;
endmodule

// File: tb/tb_decimal_entry.sv
// Directed bench for decimal_entry (DIGITS=4, WIDTH=10) with hand-computed expectations.
module tb_decimal_entry;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  decimal_entry_if #(.DIGITS(4), .WIDTH(10)) bus ();
  decimal_entry #(.DIGITS(4), .WIDTH(10)) dut (.clk(clk), .reset(rst), .bus(bus));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // one clock with the given pulses; outputs are sampled 1 ns after the edge
  task automatic step(input logic i, input logic n, input logic s, input logic c);
    bus.inc = i; bus.next = n; bus.submit = s; bus.clear = c;
    @(posedge clk); #1;
    bus.inc = 1'b0; bus.next = 1'b0; bus.submit = 1'b0; bus.clear = 1'b0;
  endtask

  // clear, then key each digit MSD first, stepping the cursor after each
  task automatic enter(input logic [15:0] bcd);
    step(0, 0, 0, 1);
    for (int p = 3; p >= 0; p--) begin
      for (int k = 0; k < int'(bcd[4*p +: 4]); k++) step(1, 0, 0, 0);
      step(0, 1, 0, 0);
    end
  endtask

  task automatic conv(input logic [9:0] ev, input logic eo, input logic junk);
    step(junk, 0, 1, 0);
    check("busy_first", bus.busy, 1);
    check("valid_first", bus.valid, 0);
    for (int k = 0; k < 3; k++) begin
      step(junk, junk, junk, 0);
      check("busy_mid", bus.busy, 1);
      check("valid_mid", bus.valid, 0);
    end
    step(0, 0, 0, 0);
    check("busy_done", bus.busy, 0);
    check("valid_done", bus.valid, 1);
    check("value", bus.value, ev);
    check("overflow", bus.overflow, eo);
    step(0, 0, 0, 0);
    check("valid_after", bus.valid, 0);
    check("value_hold", bus.value, ev);
  endtask

  int vcount;

  initial begin
    bus.inc = 0; bus.next = 0; bus.submit = 0; bus.clear = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    check("rst_digits", bus.digits, 16'h0000);
    check("rst_cursor", bus.cursor, 3);
    check("rst_busy", bus.busy, 0);
    check("rst_value", bus.value, 0);
    check("rst_valid", bus.valid, 0);
    check("rst_ovf", bus.overflow, 0);

    step(0, 1, 0, 0);
    repeat (5) step(1, 0, 0, 0);
    check("t1_digits", bus.digits, 16'h0500);
    check("t1_cursor", bus.cursor, 2);

    enter(16'h0512);
    check("t2_digits", bus.digits, 16'h0512);
    check("t2_cursor", bus.cursor, 3);
    conv(10'd512, 1'b0, 1'b0);

    enter(16'h1024);
    conv(10'h3FF, 1'b1, 1'b0);

    step(0, 0, 0, 1);
    repeat (9) step(1, 0, 0, 0);
    check("t4_nine", bus.digits, 16'h9000);
    step(1, 0, 0, 0);
    check("t4_wrap_digit", bus.digits, 16'h0000);
    repeat (3) step(0, 1, 0, 0);
    check("t4_cursor0", bus.cursor, 0);
    step(0, 1, 0, 0);
    check("t4_cursor_wrap", bus.cursor, 3);
    step(1, 1, 0, 0);
    check("t4_incnext_digits", bus.digits, 16'h1000);
    check("t4_incnext_cursor", bus.cursor, 2);
    step(0, 0, 1, 1);
    check("t4_clear_over_submit", bus.busy, 0);
    check("t4_clear_digits", bus.digits, 16'h0000);

    enter(16'h0007);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    check("t5_busy", bus.busy, 0);
    check("t5_digits", bus.digits, 16'h0000);
    check("t5_cursor", bus.cursor, 3);
    vcount = 0;
    for (int k = 0; k < 6; k++) begin
      step(0, 0, 0, 0);
      if (bus.valid) vcount++;
    end
    check("t5_no_valid", vcount, 0);
    check("t5_value_hold", bus.value, 10'h3FF);
    check("t5_ovf_hold", bus.overflow, 1);

    enter(16'h0999);
    conv(10'd999, 1'b0, 1'b1);
`ifdef ENTRY_AUTOCLEAR_EN
    check("t6_digits", bus.digits, 16'h0000);
`else
    check("t6_digits", bus.digits, 16'h0999);
`endif
    check("t6_cursor", bus.cursor, 3);

    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check("rstmid_busy", bus.busy, 0);
    check("rstmid_digits", bus.digits, 16'h0000);
    check("rstmid_value", bus.value, 0);
    vcount = 0;
    for (int k = 0; k < 6; k++) begin
      step(0, 0, 0, 0);
      if (bus.valid) vcount++;
    end
    check("rstmid_no_valid", vcount, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
